// File: rtl/mac_filtro_pkg.sv
// Shared constants for the Q7.8 filter datapath and its controller.
package filtro_pkg;
  localparam int unsigned DW    = 16;
  localparam int unsigned NCOEF = 5;
  localparam int unsigned FRAC  = 8;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
endpackage

// File: rtl/mac_filtro_if.sv
// Controller/host bus of the MAC filter datapath.
interface mac_filtro_if #(parameter int unsigned DW = filtro_pkg::DW);
  logic          paso;
  logic [2:0]    sel_cons;
  logic [1:0]    sel_fk;
  logic          sel_ac;
  logic          listo;
  logic          muestra;
  logic [DW-1:0] x_in;
  logic          coef_we;
  logic [2:0]    coef_addr;
  logic [DW-1:0] coef_din;
  logic [DW-1:0] y;
  logic          y_valid;
  logic          ovf;
  logic          err;

  modport master (
    output paso, sel_cons, sel_fk, sel_ac, listo, muestra, x_in,
           coef_we, coef_addr, coef_din,
    input  y, y_valid, ovf, err
  );

  modport slave (
    input  paso, sel_cons, sel_fk, sel_ac, listo, muestra, x_in,
           coef_we, coef_addr, coef_din,
    output y, y_valid, ovf, err
  );
endinterface

// File: rtl/mac_filtro_mult_sat_q78.sv
// Combinational Q7.8 multiply: full-width product, arithmetic shift, saturate.
module mult_sat_q78
  import filtro_pkg::*;
#(
  parameter int unsigned DW = filtro_pkg::DW
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] p,
  output logic                 sat
);
  localparam logic signed [2*DW-1:0] HI = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] full;
  logic signed [2*DW-1:0] shifted;

  // Product, rescale, clamp to DW limits
  always_comb begin
    full    = a * b;
    shifted = full >>> FRAC;
    sat     = 1'b0;
    p       = shifted[DW-1:0];
    if (shifted > HI) begin
      p   = HI[DW-1:0];
      sat = 1'b1;
    end else if (shifted < LO) begin
      p   = LO[DW-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/mac_filtro.sv
// MAC filter datapath: sample shift line, coefficient bank, saturating accumulator.
module mac_filtro
  import filtro_pkg::*;
#(
  parameter int unsigned DW    = filtro_pkg::DW,
  parameter int unsigned NCOEF = filtro_pkg::NCOEF
) (
  input  logic         clk,
  input  logic         reset,
  mac_filtro_if.slave  bus
);
  localparam logic signed [DW-1:0] LIM_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] LIM_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] f_q    [3];
  logic signed [DW-1:0] f_d    [3];
  logic signed [DW-1:0] coef_q [NCOEF];
  logic signed [DW-1:0] coef_d [NCOEF];
  logic signed [DW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;

  logic signed [DW-1:0] coef_op, samp_op, prod_raw, prod, acc_next, sum_sat;
  logic signed [DW:0]   sum;
  logic                 cons_ok, sel_ok, mul_sat, add_sat;

  // Operand selection; out-of-range selects read as zero
  always_comb begin
    cons_ok = 32'(bus.sel_cons) < NCOEF;
    sel_ok  = cons_ok && (bus.sel_fk != 2'd3);
    coef_op = '0;
    for (int unsigned i = 0; i < NCOEF; i++) begin
      if (32'(bus.sel_cons) == i) coef_op = coef_q[i];
    end
    case (bus.sel_fk)
      2'd0:    samp_op = f_q[0];
      2'd1:    samp_op = f_q[1];
      2'd2:    samp_op = f_q[2];
      default: samp_op = '0;
    endcase
  end

  mult_sat_q78 #(.DW(DW)) u_mult (
    .a   (coef_op),
    .b   (samp_op),
    .p   (prod_raw),
    .sat (mul_sat)
  );

  // Gate the product and form the saturated accumulate candidate
  always_comb begin
    prod    = sel_ok ? prod_raw : '0;
    sum     = {acc_q[DW-1], acc_q} + {prod[DW-1], prod};
    add_sat = sum[DW] != sum[DW-1];
    sum_sat = add_sat ? (sum[DW] ? LIM_MIN : LIM_MAX) : sum[DW-1:0];
    acc_next = bus.sel_ac ? sum_sat : prod;
  end

  // Next-state for accumulator, result, flags, coefficient and sample registers
  always_comb begin
    f_d       = f_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    y_valid_d = bus.paso & bus.listo;
    if (bus.paso) begin
      acc_d = acc_next;
      if (bus.listo) y_d = acc_next;
      if ((sel_ok && mul_sat) || (bus.sel_ac && add_sat)) ovf_d = 1'b1;
      if (!sel_ok) err_d = 1'b1;
    end
    if (bus.coef_we) begin
      if (32'(bus.coef_addr) < NCOEF) begin
        for (int unsigned i = 0; i < NCOEF; i++) begin
          if (32'(bus.coef_addr) == i) coef_d[i] = bus.coef_din;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    if (bus.muestra) begin
      f_d[2] = f_q[1];
      f_d[1] = f_q[0];
      f_d[0] = bus.x_in;
    end
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q       <= '{default: '0};
      coef_q    <= '{default: '0};
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      f_q       <= f_d;
      coef_q    <= coef_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_mac_filtro.sv
// Self-checking bench for mac_filtro: directed cases plus randomized traffic.
module tb_mac_filtro;
  localparam int NC = 5;

  logic clk = 1'b0;
  logic reset;

  mac_filtro_if #(.DW(16)) bus();

  mac_filtro #(.DW(16), .NCOEF(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Reference state, plain integers
  int m_f [3];
  int m_c [8];
  int m_acc, m_y;
  bit m_yv, m_ovf, m_err;

  function automatic int clamp16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int s16(logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    longint p;
    int prod, nacc;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_f[i] = 0;
      for (int i = 0; i < 8; i++) m_c[i] = 0;
      m_acc = 0; m_y = 0; m_yv = 0; m_ovf = 0; m_err = 0;
      return;
    end
    if (bus.paso) begin
      prod = 0;
      if (int'(bus.sel_cons) < NC && bus.sel_fk != 2'd3) begin
        p = (longint'(m_c[bus.sel_cons]) * longint'(m_f[bus.sel_fk])) >>> 8;
        prod = clamp16(p);
        if (p != longint'(prod)) m_ovf = 1;
      end else begin
        m_err = 1;
      end
      if (bus.sel_ac) begin
        p = longint'(m_acc) + longint'(prod);
        nacc = clamp16(p);
        if (p != longint'(nacc)) m_ovf = 1;
      end else begin
        nacc = prod;
      end
      m_acc = nacc;
      if (bus.listo) m_y = nacc;
    end
    m_yv = bus.paso && bus.listo;
    if (bus.coef_we) begin
      if (int'(bus.coef_addr) < NC) m_c[bus.coef_addr] = s16(bus.coef_din);
      else m_err = 1;
    end
    if (bus.muestra) begin
      m_f[2] = m_f[1];
      m_f[1] = m_f[0];
      m_f[0] = s16(bus.x_in);
    end
  endtask

  // One clock of stimulus; model advances on the same edge as the DUT
  task automatic drive(bit rs, bit pa, int cons, int fk, bit ac, bit li,
                       bit mu, int x, bit we, int addr, int din);
    reset        = rs;
    bus.paso     = pa;
    bus.sel_cons = 3'(cons);
    bus.sel_fk   = 2'(fk);
    bus.sel_ac   = ac;
    bus.listo    = li;
    bus.muestra  = mu;
    bus.x_in     = 16'(x);
    bus.coef_we  = we;
    bus.coef_addr = 3'(addr);
    bus.coef_din = 16'(din);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();                 drive(0,0,0,0,0,0,0,0,0,0,0); endtask
  task automatic do_reset();             drive(1,0,0,0,0,0,0,0,0,0,0); endtask
  task automatic set_coef(int a, int d); drive(0,0,0,0,0,0,0,0,1,a,d); endtask
  task automatic push(int x);            drive(0,0,0,0,0,0,1,x,0,0,0); endtask
  task automatic step(int c, int f, bit ac, bit li); drive(0,1,c,f,ac,li,0,0,0,0,0); endtask

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (cmp_en) begin
      check("y",       {16'h0, bus.y},      {16'h0, m_y[15:0]});
      check("y_valid", {31'h0, bus.y_valid}, {31'h0, m_yv});
      check("ovf",     {31'h0, bus.ovf},     {31'h0, m_ovf});
      check("err",     {31'h0, bus.err},     {31'h0, m_err});
    end
  end

  initial begin
    cmp_en = 1'b1;
    do_reset();
    check("reset_y", {16'h0, bus.y}, 32'h0);

    // Three-tap sum
    set_coef(0, 16'h0100); set_coef(1, 16'h0080); set_coef(2, 16'h0040);
    set_coef(3, 0); set_coef(4, 0);
    push(16'h0200); push(16'h0100); push(16'h0400);
    step(0, 0, 0, 0); step(1, 1, 1, 0); step(2, 2, 1, 1);
    check("r037_y",     {16'h0, bus.y}, 32'h0500);
    check("r037_model", m_y, 32'h0500);
    check("r037_valid", {31'h0, bus.y_valid}, 32'h1);
    idle();
    check("r037_valid_drop", {31'h0, bus.y_valid}, 32'h0);

    // Multiply saturation and sticky ovf
    do_reset();
    set_coef(0, 16'h7F00); push(16'h7F00);
    step(0, 0, 0, 1);
    check("r038_y",   {16'h0, bus.y}, 32'h7FFF);
    check("r038_ovf", {31'h0, bus.ovf}, 32'h1);
    idle(); idle(); idle();
    check("r038_ovf_sticky", {31'h0, bus.ovf}, 32'h1);

    // Invalid sample select after nonzero accumulator
    step(0, 3, 0, 1);
    check("r039_y",   {16'h0, bus.y}, 32'h0);
    check("r039_err", {31'h0, bus.err}, 32'h1);

    // Shift and step in the same cycle
    do_reset();
    set_coef(0, 16'h0100); push(16'h0100);
    drive(0, 1, 0, 0, 0, 1, 1, 16'h0300, 0, 0, 0);
    check("r040_y", {16'h0, bus.y}, 32'h0100);
    step(0, 0, 0, 1);
    check("r040_next", {16'h0, bus.y}, 32'h0300);

    // Reset mid-sequence
    do_reset();
    set_coef(0, 16'h0100); push(16'h0100);
    step(0, 0, 0, 0);
    do_reset();
    check("r041_rst_y", {16'h0, bus.y}, 32'h0);
    step(0, 0, 1, 1);
    check("r041_y",     {16'h0, bus.y}, 32'h0);
    check("r041_valid", {31'h0, bus.y_valid}, 32'h1);

    // Coefficient write colliding with a step
    do_reset();
    set_coef(0, 16'h0100); push(16'h0100);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0200);
    check("r042_y", {16'h0, bus.y}, 32'h0100);
    step(0, 0, 0, 1);
    check("r042_next", {16'h0, bus.y}, 32'h0200);

    // Out-of-range coefficient write
    do_reset();
    set_coef(5, 16'h1234);
    check("coef_addr_err", {31'h0, bus.err}, 32'h1);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
            $urandom_range(0, 1),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 16'h03FF),
            $urandom_range(0, 4) == 0,
            ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16'hFFFF) : $urandom_range(0, 16'h0200));
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
